player_motion_ctrl: RTL and testbench

- Sequences the player sprite's on-screen origin from the four active-low direction buttons.
- Synchronises and debounces the buttons, runs a per-axis press/auto-repeat state machine, and commits position changes only at frame start, so the sprite never tears mid-frame.
- Drives the horizontal/vertical origin consumed by the sprite ROM address/compare datapath.

---
 rtl/player_motion_ctrl_if.sv | 24 ++
 rtl/player_motion_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_ctrl_if.sv
// Button, frame-timing and sprite-origin signals between the board I/O and the motion controller.
// Buttons are raw active-low levels; origins and the moved pulse are registered by the controller.
// No handshake: the controller samples inputs every clk and presents outputs every clk.
interface player_motion_ctrl_if;
  logic       v_up;
  logic       v_down;
  logic       h_left;
  logic       h_right;
  logic       frame_sync;
  logic       freeze;
  logic [9:0] horizonal;
  logic [8:0] veritical;
  logic       moved;

  modport master (
    output v_up, v_down, h_left, h_right, frame_sync, freeze,
    input  horizonal, veritical, moved
  );

  modport slave (
    input  v_up, v_down, h_left, h_right, frame_sync, freeze,
    output horizonal, veritical, moved
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player sprite origin sequencer: debounced buttons drive per-axis press/auto-repeat FSMs.
// Latency: button -> 2 sync + DEBOUNCE_CYCLES + 1; frame_sync rise -> commit edge 2 cycles.
// No backpressure: origins change only on the frame tick, freeze discards pending steps.
module player_motion_ctrl #(
  parameter int STEP            = 20,
  parameter int X_MAX           = 200,
  parameter int Y_MAX           = 200,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_FRAMES   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  player_motion_ctrl_if.slave  bus
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int              RF_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REPEAT_FRAMES - 1);
  localparam logic [10:0]     STEP_W  = 11'(STEP);
  localparam logic [10:0]     X_LIM   = 11'(X_MAX);
  localparam logic [10:0]     Y_LIM   = 11'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ARM, HOLD} axis_state_t;

  // Button order everywhere: [0]=up, [1]=down, [2]=left, [3]=right
  logic [3:0]      raw_n;
  logic [3:0]      sync1_n;
  logic [3:0]      sync2_n;
  logic [3:0]      pressed_s;
  logic [3:0]      db_q;
  logic [DB_W-1:0] db_cnt [4];

  logic fs_q;
  logic fs_q2;
  logic tick;

  // Axis index: [0]=horizontal, [1]=vertical. Positions kept 11 bits wide so +STEP never overflows.
  logic [1:0]      dir_nz;
  logic [1:0]      dir_neg;
  axis_state_t     state     [2];
  logic [1:0]      dir_q;
  logic [RF_W-1:0] frame_cnt [2];
  logic [10:0]     pos       [2];
  logic [10:0]     nxt_pos   [2];
  logic [1:0]      step_en;
  logic            moved_nxt;
  logic            moved_q;

  function automatic logic [10:0] step_pos(input logic [10:0] p, input logic neg,
                                           input logic [10:0] lim);
    logic [10:0] sum;
    sum = p + STEP_W;
    if (neg) step_pos = (p < STEP_W) ? lim : (p - STEP_W);
    else     step_pos = (sum > lim) ? 11'd0 : sum;
  endfunction

  assign raw_n     = {bus.h_right, bus.h_left, bus.v_down, bus.v_up};
  assign pressed_s = ~sync2_n;

  // Two-flop synchroniser per button; reset state is "released" (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= raw_n;
      sync2_n <= sync1_n;
    end
  end

  // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        db_q[i]   <= 1'b0;
        db_cnt[i] <= '0;
      end else if (pressed_s[i] == db_q[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DB_LAST) begin
        db_q[i]   <= pressed_s[i];
        db_cnt[i] <= '0;
      end else begin
        db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  // Frame tick: single pulse per frame from the registered rising edge of frame_sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q  <= 1'b0;
      fs_q2 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      fs_q  <= bus.frame_sync;
      fs_q2 <= fs_q;
      tick  <= fs_q & ~fs_q2;
    end
  end

  // Opposing buttons on one axis cancel out to "no direction".
  assign dir_nz[0]  = db_q[3] ^ db_q[2];
  assign dir_neg[0] = db_q[2] & ~db_q[3];
  assign dir_nz[1]  = db_q[1] ^ db_q[0];
  assign dir_neg[1] = db_q[0] & ~db_q[1];

  // Step decision and wrapped next position per axis; ARM steps with the latest sign.
  always_comb begin
    step_en   = '0;
    moved_nxt = 1'b0;
    for (int a = 0; a < 2; a++) begin
      nxt_pos[a] = step_pos(pos[a], dir_neg[a], (a == 0) ? X_LIM : Y_LIM);
      if (!bus.freeze && tick && dir_nz[a]) begin
        case (state[a])
          ARM:     step_en[a] = 1'b1;
          HOLD:    step_en[a] = (dir_neg[a] == dir_q[a]) && (frame_cnt[a] == RF_LAST);
          default: step_en[a] = 1'b0;
        endcase
      end
      if (step_en[a] && (nxt_pos[a] != pos[a])) moved_nxt = 1'b1;
    end
  end

  // Per-axis IDLE/ARM/HOLD sequencer with origin commit and registered moved pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        state[a]     <= IDLE;
        frame_cnt[a] <= '0;
        pos[a]       <= '0;
      end
      dir_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      moved_q <= moved_nxt;
      for (int a = 0; a < 2; a++) begin
        if (step_en[a]) pos[a] <= nxt_pos[a];
        if (bus.freeze) begin
          state[a]     <= IDLE;
          frame_cnt[a] <= '0;
        end else begin
          case (state[a])
            IDLE: begin
              frame_cnt[a] <= '0;
              if (dir_nz[a]) begin
                state[a] <= ARM;
                dir_q[a] <= dir_neg[a];
              end
            end
            ARM: begin
              dir_q[a] <= dir_neg[a];
              if (!dir_nz[a]) begin
                state[a] <= IDLE;
              end else if (tick) begin
                state[a]     <= HOLD;
                frame_cnt[a] <= '0;
              end
            end
            HOLD: begin
              if (!dir_nz[a]) begin
                state[a] <= IDLE;
              end else if (dir_neg[a] != dir_q[a]) begin
                state[a] <= ARM;
                dir_q[a] <= dir_neg[a];
              end else if (tick) begin
                frame_cnt[a] <= (frame_cnt[a] == RF_LAST) ? '0 : frame_cnt[a] + RF_W'(1);
              end
            end
            default: state[a] <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.horizonal = pos[0][9:0];
  assign bus.veritical = pos[1][8:0];
  assign bus.moved     = moved_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
`timescale 1ns/1ps
module tb_player_motion_ctrl;
  localparam int DB   = 4;
  localparam int RF   = 20;
  localparam int STEP = 20;
  localparam int XM   = 200;
  localparam int YM   = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  player_motion_ctrl_if ifc();

  player_motion_ctrl #(
    .STEP(STEP), .X_MAX(XM), .Y_MAX(YM), .DEBOUNCE_CYCLES(DB), .REPEAT_FRAMES(RF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int h; int v;} exp_t;
  exp_t exp_q[$];
  exp_t got_e;

  // Reference model: origin, held direction per axis and ticks seen since that direction began.
  int m_h = 0, m_v = 0;
  int dx = 0, dy = 0;
  int k_x = 0, k_y = 0;
  bit frz = 1'b0;
  logic [3:0] rb;

  function automatic int dir_of(input bit plus, input bit minus);
    if (plus && !minus) return 1;
    if (minus && !plus) return -1;
    return 0;
  endfunction

  function automatic int step_ref(input int p, input int d, input int lim);
    if (d > 0) return (p + STEP > lim) ? 0 : p + STEP;
    return (p < STEP) ? lim : p - STEP;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic press(input bit up, input bit down, input bit left, input bit right);
    int nx, ny;
    @(posedge clk); #1;
    ifc.v_up    = !up;
    ifc.v_down  = !down;
    ifc.h_left  = !left;
    ifc.h_right = !right;
    nx = dir_of(right, left);
    ny = dir_of(down, up);
    if (nx != dx) k_x = 0;
    if (ny != dy) k_y = 0;
    dx = nx;
    dy = ny;
    repeat (DB + 6) @(posedge clk);
  endtask

  // Held direction steps on the 1st tick, then every RF ticks after that.
  task automatic model_tick();
    int nh, nv;
    nh = m_h;
    nv = m_v;
    if (!frz) begin
      if (dx != 0) begin
        k_x++;
        if ((k_x - 1) % RF == 0) nh = step_ref(m_h, dx, XM);
      end
      if (dy != 0) begin
        k_y++;
        if ((k_y - 1) % RF == 0) nv = step_ref(m_v, dy, YM);
      end
      if (nh != m_h || nv != m_v) exp_q.push_back('{nh, nv});
      m_h = nh;
      m_v = nv;
    end
  endtask

  task automatic frame(input int w);
    @(posedge clk); #1;
    ifc.frame_sync = 1'b1;
    model_tick();
    repeat (w) @(posedge clk);
    #1 ifc.frame_sync = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic set_freeze(input bit f);
    @(posedge clk); #1;
    ifc.freeze = f;
    frz = f;
    if (f) begin
      k_x = 0;
      k_y = 0;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ifc.v_up = 1'b1; ifc.v_down = 1'b1; ifc.h_left = 1'b1; ifc.h_right = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_h = 0; m_v = 0; dx = 0; dy = 0; k_x = 0; k_y = 0;
    chk("rst_h", int'(ifc.horizonal), 0);
    chk("rst_v", int'(ifc.veritical), 0);
    chk("rst_moved", int'(ifc.moved), 0);
    repeat (DB + 6) @(posedge clk);
  endtask

  // Wide frame_sync: commit 2 edges after the first sampling edge, moved for one cycle only.
  task automatic frame_lat();
    int old_v;
    @(posedge clk); #1;
    ifc.frame_sync = 1'b1;
    old_v = int'(ifc.veritical);
    model_tick();
    @(posedge clk); @(negedge clk);
    chk("lat_e0_moved", int'(ifc.moved), 0);
    @(posedge clk); @(negedge clk);
    chk("lat_e1_moved", int'(ifc.moved), 0);
    chk("lat_e1_v", int'(ifc.veritical), old_v);
    @(posedge clk); @(negedge clk);
    chk("lat_e2_moved", int'(ifc.moved), 1);
    chk("lat_e2_v", int'(ifc.veritical), m_v);
    @(posedge clk); @(negedge clk);
    chk("lat_e3_moved", int'(ifc.moved), 0);
    repeat (4) @(posedge clk);
    #1 ifc.frame_sync = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  // Monitor: every moved pulse must match the next expected origin; no silent origin changes.
  logic       rst_d = 1'b1;
  logic [9:0] prev_h = '0;
  logic [8:0] prev_v = '0;
  always @(negedge clk) begin
    if (!rst && !rst_d) begin
      if (ifc.moved) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL moved_unexpected got h=%0d v=%0d want no move", ifc.horizonal, ifc.veritical);
        end else begin
          got_e = exp_q.pop_front();
          if (int'(ifc.horizonal) != got_e.h || int'(ifc.veritical) != got_e.v) begin
            errors++;
            $display("FAIL origin got h=%0d v=%0d want h=%0d v=%0d",
                     ifc.horizonal, ifc.veritical, got_e.h, got_e.v);
          end
        end
      end else if (ifc.horizonal != prev_h || ifc.veritical != prev_v) begin
        checks++;
        errors++;
        $display("FAIL silent_change got h=%0d v=%0d want h=%0d v=%0d",
                 ifc.horizonal, ifc.veritical, prev_h, prev_v);
      end
    end
    rst_d  <= rst;
    prev_h <= ifc.horizonal;
    prev_v <= ifc.veritical;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.v_up = 1'b1; ifc.v_down = 1'b1; ifc.h_left = 1'b1; ifc.h_right = 1'b1;
    ifc.frame_sync = 1'b0;
    ifc.freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("init_h", int'(ifc.horizonal), 0);
    chk("init_v", int'(ifc.veritical), 0);
    chk("init_moved", int'(ifc.moved), 0);
    repeat (3) @(posedge clk);

    // Hold right across 41 ticks: steps at ticks 1, 21, 41
    press(0, 0, 0, 1);
    for (int i = 0; i < 41; i++) begin
      frame(1 + i % 3);
      if (i == 2) chk("first_step_only", int'(ifc.horizonal), 20);
      if (i == 19) chk("before_repeat", int'(ifc.horizonal), 20);
    end
    chk("hold41_h", int'(ifc.horizonal), 60);
    chk("hold41_v", int'(ifc.veritical), 0);

    // Wrap boundaries
    do_reset();
    press(0, 0, 1, 0); frame(2);
    chk("wrap_left", int'(ifc.horizonal), 200);
    press(0, 0, 0, 0); press(0, 0, 0, 1); frame(2);
    chk("wrap_right", int'(ifc.horizonal), 0);
    press(0, 0, 0, 0); press(1, 0, 0, 0); frame(2);
    chk("wrap_up", int'(ifc.veritical), 200);
    press(0, 0, 0, 0);

    // Glitch one cycle short of the debounce window
    @(posedge clk); #1 ifc.h_right = 1'b0;
    repeat (DB - 1) @(posedge clk);
    #1 ifc.h_right = 1'b1;
    repeat (DB + 6) @(posedge clk);
    frame(3); frame(3);
    chk("glitch_h", int'(ifc.horizonal), 0);

    // Opposing buttons cancel
    press(0, 0, 1, 1); frame(2); frame(2);
    chk("both_lr_h", int'(ifc.horizonal), 0);
    press(0, 0, 0, 0);

    // Wide frame_sync with down pressed
    do_reset();
    press(0, 1, 0, 0);
    frame_lat();

    // Freeze mid-HOLD, release, then reset during HOLD
    frame(2); frame(2);
    set_freeze(1'b1);
    for (int i = 0; i < 5; i++) frame(2);
    chk("freeze_v", int'(ifc.veritical), 20);
    set_freeze(1'b0);
    frame(2);
    chk("unfreeze_v", int'(ifc.veritical), 40);
    frame(2);
    do_reset();
    frame(2); frame(2); frame(2);
    chk("post_rst_v", int'(ifc.veritical), 0);
    press(0, 1, 0, 0); frame(1);
    chk("repress_v", int'(ifc.veritical), 20);

    // Randomised mix of presses, frames and freeze toggles
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        rb = 4'($urandom);
        press(rb[0], rb[1], rb[2], rb[3]);
      end else if (r < 9) begin
        frame($urandom_range(1, 8));
      end else begin
        set_freeze(!frz);
      end
    end
    set_freeze(1'b0);
    frame(2);
    repeat (10) @(posedge clk);
    chk("pending_expected", exp_q.size(), 0);
    chk("final_h", int'(ifc.horizonal), m_h);
    chk("final_v", int'(ifc.veritical), m_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
